// File: rtl/rd_data2b.sv
`default_nettype none
// ============================================================================
// Module   : rd_data2b
// Purpose  : Fetches four consecutive data-memory words and packs them into
//            one 128-bit block for the AES core (word0 -> [127:96]).
// Revision : 1.0 - initial release
// ============================================================================
module rd_data2b #(
   parameter int unsigned RD_LATENCY = 1,
   parameter logic [31:0] ADDR_STEP  = 32'd4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [31:0]  addr_base,
   output logic         en_r_datamem,
   output logic [31:0]  addr_rd,
   input  logic [31:0]  data_rd,
   output logic [127:0] data_aes_in,
   output logic         aes_valid,
   input  logic         aes_ready,
   output logic         busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   logic [1:0]            state_q,     state_d;
   logic [1:0]            issue_cnt_q, issue_cnt_d;
   logic [1:0]            cap_cnt_q,   cap_cnt_d;
   logic                  en_q,        en_d;
   logic [31:0]           addr_q,      addr_d;
   logic [127:0]          blk_q,       blk_d;
   logic                  valid_q,     valid_d;
   logic [RD_LATENCY-1:0] pipe_q,      pipe_d;

   logic                  w_rd_hit;
   logic                  w_capture;

   // Request-enable delay line; its tail marks the cycle data_rd is valid.
   generate
      if (RD_LATENCY == 1) begin : g_pipe_one
         assign pipe_d = en_q;
      end else begin : g_pipe_multi
         assign pipe_d = {pipe_q[RD_LATENCY-2:0], en_q};
      end
   endgenerate

   assign w_rd_hit  = pipe_q[RD_LATENCY-1];
   assign w_capture = w_rd_hit && ((state_q == S_ISSUE) || (state_q == S_DRAIN));

   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      cap_cnt_d   = cap_cnt_q;
      en_d        = en_q;
      addr_d      = addr_q;
      blk_d       = blk_q;
      valid_d     = valid_q;

      if (w_capture) begin
         case (cap_cnt_q)
            2'd0:    blk_d[127:96] = data_rd;
            2'd1:    blk_d[95:64]  = data_rd;
            2'd2:    blk_d[63:32]  = data_rd;
            default: blk_d[31:0]   = data_rd;
         endcase
         cap_cnt_d = cap_cnt_q + 2'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               en_d        = 1'b1;
               addr_d      = addr_base;
               issue_cnt_d = 2'd0;
               cap_cnt_d   = 2'd0;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (issue_cnt_q == 2'd3) begin
               en_d    = 1'b0;
               state_d = S_DRAIN;
            end else begin
               addr_d      = addr_q + ADDR_STEP;
               issue_cnt_d = issue_cnt_q + 2'd1;
            end
         end
         S_DRAIN: begin
            // The edge that stores word3 also raises valid.
            if (w_capture && (cap_cnt_q == 2'd3)) begin
               valid_d = 1'b1;
               state_d = S_OUT;
            end
         end
         default: begin
            if (aes_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         issue_cnt_q <= 2'd0;
         cap_cnt_q   <= 2'd0;
         en_q        <= 1'b0;
         addr_q      <= 32'd0;
         blk_q       <= 128'd0;
         valid_q     <= 1'b0;
         pipe_q      <= '0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         cap_cnt_q   <= cap_cnt_d;
         en_q        <= en_d;
         addr_q      <= addr_d;
         blk_q       <= blk_d;
         valid_q     <= valid_d;
         pipe_q      <= pipe_d;
      end
   end

   assign en_r_datamem = en_q;
   assign addr_rd      = addr_q;
   assign data_aes_in  = blk_q;
   assign aes_valid    = valid_q;
   assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rd_data2b.sv
`default_nettype none
// ============================================================================
// Module   : tb_rd_data2b
// Purpose  : Directed self-checking bench for rd_data2b (latency 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rd_data2b;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [31:0]  addr_base;
   logic         aes_ready;

   logic         en1, en3, valid1, valid3, busy1, busy3;
   logic [31:0]  addr1, addr3, data_rd1, data_rd3;
   logic [127:0] data1, data3;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   rd_data2b #(.RD_LATENCY(1), .ADDR_STEP(32'd4)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .addr_base(addr_base),
      .en_r_datamem(en1), .addr_rd(addr1), .data_rd(data_rd1),
      .data_aes_in(data1), .aes_valid(valid1), .aes_ready(aes_ready),
      .busy(busy1)
   );

   rd_data2b #(.RD_LATENCY(3), .ADDR_STEP(32'd4)) u_dut3 (
      .clk(clk), .reset(reset), .start(start), .addr_base(addr_base),
      .en_r_datamem(en3), .addr_rd(addr3), .data_rd(data_rd3),
      .data_aes_in(data3), .aes_valid(valid3), .aes_ready(aes_ready),
      .busy(busy3)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'd400:        mem_word = 32'h1111_1111;
         32'd404:        mem_word = 32'h2222_2222;
         32'd408:        mem_word = 32'h3333_3333;
         32'd412:        mem_word = 32'h4444_4444;
         32'd500:        mem_word = 32'h5555_5555;
         32'd504:        mem_word = 32'h6666_6666;
         32'd508:        mem_word = 32'h7777_7777;
         32'd512:        mem_word = 32'h8888_8888;
         32'hFFFF_FFF8:  mem_word = 32'hA0A0_A0A0;
         32'hFFFF_FFFC:  mem_word = 32'hB1B1_B1B1;
         32'h0000_0000:  mem_word = 32'hC2C2_C2C2;
         32'h0000_0004:  mem_word = 32'hD3D3_D3D3;
         default:        mem_word = 32'hDEAD_BEEF;
      endcase
   endfunction

   // Memory models: address pipelines returning data exactly L cycles later.
   logic [31:0] m1a [0:3];
   logic [31:0] m3a [0:3];
   always @(posedge clk) begin
      m1a[0] <= addr1;
      m3a[0] <= addr3;
      for (int i = 1; i < 4; i++) begin
         m1a[i] <= m1a[i-1];
         m3a[i] <= m3a[i-1];
      end
   end
   assign data_rd1 = mem_word(m1a[0]);
   assign data_rd3 = mem_word(m3a[2]);

   // Request / handshake recorder.
   logic        rec_clr = 1'b0;
   int          n1 = 0, n3 = 0, hs1 = 0, hs3 = 0;
   logic [31:0] a1 [0:7];
   always @(posedge clk) begin
      if (rec_clr) begin
         n1 <= 0; n3 <= 0; hs1 <= 0; hs3 <= 0;
      end else begin
         if (en1) begin
            if (n1 < 8) a1[n1] <= addr1;
            n1 <= n1 + 1;
         end
         if (en3) n3 <= n3 + 1;
         if (valid1 && aes_ready) hs1 <= hs1 + 1;
         if (valid3 && aes_ready) hs3 <= hs3 + 1;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      nvec++;
      if (obs !== exp_v) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_block(input logic [31:0] base);
      rec_clr   = 1'b1;
      start     = 1'b1;
      addr_base = base;
      tick();
      start     = 1'b0;
      rec_clr   = 1'b0;
   endtask

   int v1, v3, vc1, vc3;
   task automatic measure(input int n);
      v1 = 0; v3 = 0; vc1 = 0; vc3 = 0;
      for (int k = 1; k <= n; k++) begin
         tick();
         if (valid1 && v1 == 0) v1 = k;
         if (valid3 && v3 == 0) v3 = k;
         if (valid1) vc1++;
         if (valid3) vc3++;
      end
   endtask

   task automatic wait_valid1();
      for (int k = 0; k < 30 && !valid1; k++) tick();
      chk("valid_seen", {127'd0, valid1}, 128'd1);
   endtask

   localparam logic [127:0] BLK_400 = 128'h11111111_22222222_33333333_44444444;
   localparam logic [127:0] BLK_500 = 128'h55555555_66666666_77777777_88888888;
   localparam logic [127:0] BLK_WRP = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;

   logic         stable;
   logic [127:0] held;

   initial begin
      reset = 1'b1; start = 1'b0; addr_base = 32'd0; aes_ready = 1'b0;
      tick(); tick();
      chk("rst_en",    {127'd0, en1},    128'd0);
      chk("rst_addr",  {96'd0, addr1},   128'd0);
      chk("rst_data",  data1,            128'd0);
      chk("rst_valid", {127'd0, valid1}, 128'd0);
      chk("rst_busy",  {127'd0, busy1},  128'd0);
      reset = 1'b0;
      tick();

      // Basic load, ready already high, both latencies.
      aes_ready = 1'b1;
      start_block(32'd400);
      chk("t1_en0",   {127'd0, en1},  128'd1);
      chk("t1_addr0", {96'd0, addr1}, 128'd400);
      chk("t1_busy",  {127'd0, busy1}, 128'd1);
      measure(12);
      chk("t1_vlat",   v1,  5);
      chk("t1_vwidth", vc1, 1);
      chk("t1_block",  data1, BLK_400);
      chk("t1_nreq",   n1,  4);
      chk("t1_a0",     {96'd0, a1[0]}, 128'd400);
      chk("t1_a1",     {96'd0, a1[1]}, 128'd404);
      chk("t1_a2",     {96'd0, a1[2]}, 128'd408);
      chk("t1_a3",     {96'd0, a1[3]}, 128'd412);
      chk("t1_hs",     hs1, 1);
      chk("t2_vlat",   v3,  7);
      chk("t2_vwidth", vc3, 1);
      chk("t2_block",  data3, BLK_400);
      chk("t2_nreq",   n3,  4);
      chk("t1_idle",   {127'd0, busy1}, 128'd0);

      // Back-pressure: hold ready low for 10 cycles after valid.
      aes_ready = 1'b0;
      start_block(32'd500);
      wait_valid1();
      held   = data1;
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (!valid1 || !busy1 || data1 !== held) stable = 1'b0;
      end
      chk("t3_stable", {127'd0, stable}, 128'd1);
      chk("t3_block",  data1, BLK_500);
      aes_ready = 1'b1;
      tick();
      chk("t3_valid_off", {127'd0, valid1}, 128'd0);
      chk("t3_busy_off",  {127'd0, busy1},  128'd0);
      chk("t3_hs",        hs1, 1);
      chk("t3_keep",      data1, BLK_500);
      measure(6);

      // Extra starts during ISSUE, OUT and on the handshake edge.
      aes_ready = 1'b0;
      start_block(32'd400);
      tick();
      start = 1'b1; addr_base = 32'd500;
      tick();
      start = 1'b0;
      wait_valid1();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      aes_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      measure(10);
      chk("t4_nreq1",  n1, 4);
      chk("t4_nreq3",  n3, 4);
      chk("t4_hs1",    hs1, 1);
      chk("t4_hs3",    hs3, 1);
      chk("t4_vc1",    vc1, 0);
      chk("t4_block",  data1, BLK_400);
      chk("t4_block3", data3, BLK_400);
      chk("t4_idle",   {127'd0, busy1}, 128'd0);

      // Address wrap.
      start_block(32'hFFFF_FFF8);
      measure(12);
      chk("t5_a0",    {96'd0, a1[0]}, {96'd0, 32'hFFFF_FFF8});
      chk("t5_a1",    {96'd0, a1[1]}, {96'd0, 32'hFFFF_FFFC});
      chk("t5_a2",    {96'd0, a1[2]}, 128'd0);
      chk("t5_a3",    {96'd0, a1[3]}, 128'd4);
      chk("t5_block", data1, BLK_WRP);

      // Asynchronous reset after the second capture, then a fresh block.
      start_block(32'd400);
      tick(); tick(); tick();
      #2 reset = 1'b1;
      #1;
      chk("t6_en",    {127'd0, en1},    128'd0);
      chk("t6_addr",  {96'd0, addr1},   128'd0);
      chk("t6_data",  data1,            128'd0);
      chk("t6_valid", {127'd0, valid1}, 128'd0);
      chk("t6_busy",  {127'd0, busy1},  128'd0);
      tick();
      reset = 1'b0;
      tick(); tick();
      chk("t6_nocap", data1, 128'd0);
      start_block(32'd500);
      measure(12);
      chk("t6_vlat",   v1, 5);
      chk("t6_block",  data1, BLK_500);
      chk("t6_vlat3",  v3, 7);
      chk("t6_block3", data3, BLK_500);
      chk("t6_nreq",   n1, 4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire
